// File: rtl/h_or_pkg.sv
// Shared constants for the h_or OR primitive block and its registers.
package h_or_pkg;

    localparam int WAY_N     = 8;
    localparam int WIDTH_MAX = 64;

    // Registered outputs return to all-zeros on reset, whatever their width.
    localparam logic [WIDTH_MAX-1:0] REG_RESET = '0;

endpackage

// File: rtl/h_or_or_reg.sv
// or_reg: WIDTH-bit enable register with asynchronous active-high reset.
module or_reg
    import h_or_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= REG_RESET[WIDTH-1:0];
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/h_or.sv
// h_or: scalar, bus and 8-way OR with enabled registered copies and a
// sticky flag recording that the 8-way OR was captured high.
module h_or
    import h_or_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             a,
    input  logic             b,
    output logic             out,
    input  logic [WIDTH-1:0] bus_a,
    input  logic [WIDTH-1:0] bus_b,
    output logic [WIDTH-1:0] bus_out,
    input  logic [WAY_N-1:0] way_in,
    output logic             way_out,
    input  logic             en,
    input  logic             clr,
    output logic             out_q,
    output logic [WIDTH-1:0] bus_out_q,
    output logic             way_out_q,
    output logic             sticky
);

    logic [1:0] bit_q;

    assign out     = a | b;
    assign bus_out = bus_a | bus_b;
    assign way_out = |way_in;

    or_reg #(
        .WIDTH(WIDTH)
    ) u_bus_reg (
        .clk  (clk),
        .reset(reset),
        .en   (en),
        .d    (bus_out),
        .q    (bus_out_q)
    );

    // The two scalar results share one register so they always move together.
    or_reg #(
        .WIDTH(2)
    ) u_bit_reg (
        .clk  (clk),
        .reset(reset),
        .en   (en),
        .d    ({out, way_out}),
        .q    (bit_q)
    );

    assign out_q     = bit_q[1];
    assign way_out_q = bit_q[0];

    // clr outranks a simultaneous capture and does not depend on en.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sticky <= 1'b0;
        end else if (clr) begin
            sticky <= 1'b0;
        end else if (en && way_out) begin
            sticky <= 1'b1;
        end
    end

endmodule

// File: tb/tb_h_or.sv
// Self-checking bench for h_or: direct combinational checks plus a queue
// scoreboard for the registered outputs against a behavioural model.
module tb_h_or;

    localparam int W = 16;

    logic         clk;
    logic         reset;
    logic         a;
    logic         b;
    logic         out;
    logic [W-1:0] bus_a;
    logic [W-1:0] bus_b;
    logic [W-1:0] bus_out;
    logic [7:0]   way_in;
    logic         way_out;
    logic         en;
    logic         clr;
    logic         out_q;
    logic [W-1:0] bus_out_q;
    logic         way_out_q;
    logic         sticky;

    typedef struct {
        logic         o;
        logic [W-1:0] bus;
        logic         w;
        logic         s;
    } exp_t;

    exp_t sb[$];

    int checks;
    int errors;

    // Reference model state for the registered outputs.
    logic         m_out_q;
    logic [W-1:0] m_bus_q;
    logic         m_way_q;
    logic         m_sticky;

    h_or #(
        .WIDTH(W)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .a        (a),
        .b        (b),
        .out      (out),
        .bus_a    (bus_a),
        .bus_b    (bus_b),
        .bus_out  (bus_out),
        .way_in   (way_in),
        .way_out  (way_out),
        .en       (en),
        .clr      (clr),
        .out_q    (out_q),
        .bus_out_q(bus_out_q),
        .way_out_q(way_out_q),
        .sticky   (sticky)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] modelBusOr(input logic [W-1:0] x, input logic [W-1:0] y);
        logic [W-1:0] r;
        for (int i = 0; i < W; i++) begin
            r[i] = (x[i] == 1'b1) || (y[i] == 1'b1);
        end
        return r;
    endfunction

    task automatic modelReset();
        m_out_q  = 1'b0;
        m_bus_q  = '0;
        m_way_q  = 1'b0;
        m_sticky = 1'b0;
    endtask

    // Drive one cycle's inputs at the falling edge, check the combinational
    // results, then queue what the registers must hold after the next rising edge.
    task automatic applyStimulus(input logic ia, input logic ib, input logic [W-1:0] ba,
                                 input logic [W-1:0] bb, input logic [7:0] wi,
                                 input logic ien, input logic iclr);
        logic         e_out;
        logic [W-1:0] e_bus;
        logic         e_way;
        exp_t         e;
        @(negedge clk);
        a      = ia;
        b      = ib;
        bus_a  = ba;
        bus_b  = bb;
        way_in = wi;
        en     = ien;
        clr    = iclr;
        e_out  = (int'(ia) + int'(ib)) != 0;
        e_bus  = modelBusOr(ba, bb);
        e_way  = (wi != 8'h00);
        #1;
        checkOutput("out", 64'(out), 64'(e_out));
        checkOutput("bus_out", 64'(bus_out), 64'(e_bus));
        checkOutput("way_out", 64'(way_out), 64'(e_way));
        if (ien) begin
            m_out_q = e_out;
            m_bus_q = e_bus;
            m_way_q = e_way;
        end
        if (iclr) begin
            m_sticky = 1'b0;
        end else if (ien && e_way) begin
            m_sticky = 1'b1;
        end
        e.o = m_out_q;
        e.bus = m_bus_q;
        e.w = m_way_q;
        e.s = m_sticky;
        sb.push_back(e);
    endtask

    // Monitor: after each rising edge, compare registers against the oldest expectation.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            checkOutput("out_q", 64'(out_q), 64'(e.o));
            checkOutput("bus_out_q", 64'(bus_out_q), 64'(e.bus));
            checkOutput("way_out_q", 64'(way_out_q), 64'(e.w));
            checkOutput("sticky", 64'(sticky), 64'(e.s));
        end
    end

    logic [1:0]   tt_ab  [4];
    logic [W-1:0] bus_va [3];
    logic [W-1:0] bus_vb [3];
    logic [W-1:0] bus_ve [3];
    logic [7:0]   way_v  [3];
    logic         way_e  [3];

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        a      = 1'b0;
        b      = 1'b0;
        bus_a  = '0;
        bus_b  = '0;
        way_in = 8'h00;
        en     = 1'b0;
        clr    = 1'b0;
        modelReset();

        #2;
        checkOutput("reset out_q", 64'(out_q), 64'd0);
        checkOutput("reset bus_out_q", 64'(bus_out_q), 64'd0);
        checkOutput("reset way_out_q", 64'(way_out_q), 64'd0);
        checkOutput("reset sticky", 64'(sticky), 64'd0);

        // Combinational paths during reset, each pattern held 100 ns.
        tt_ab = '{2'b00, 2'b01, 2'b10, 2'b11};
        for (int i = 0; i < 4; i++) begin
            a = tt_ab[i][1];
            b = tt_ab[i][0];
            #50;
            checkOutput($sformatf("truth %0d%0d", a, b), 64'(out), 64'(i != 0));
            #50;
        end

        bus_va = '{16'h00F0, 16'h0000, 16'hFFFF};
        bus_vb = '{16'h0F00, 16'h0000, 16'h0001};
        bus_ve = '{16'h0FF0, 16'h0000, 16'hFFFF};
        for (int i = 0; i < 3; i++) begin
            bus_a = bus_va[i];
            bus_b = bus_vb[i];
            #10;
            checkOutput($sformatf("bus vec %0d", i), 64'(bus_out), 64'(bus_ve[i]));
        end

        way_v = '{8'h00, 8'h80, 8'h01};
        way_e = '{1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 3; i++) begin
            way_in = way_v[i];
            #10;
            checkOutput($sformatf("way vec %0d", i), 64'(way_out), 64'(way_e[i]));
        end
        checkOutput("held reset out_q", 64'(out_q), 64'd0);

        @(negedge clk);
        reset = 1'b0;

        // Latency and enable hold.
        applyStimulus(1'b1, 1'b0, 16'h0000, 16'h0000, 8'h00, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b0, 16'h0000, 16'h0000, 8'h00, 1'b0, 1'b0);
        end
        applyStimulus(1'b0, 1'b0, 16'h0000, 16'h0000, 8'h00, 1'b1, 1'b0);

        // Async reset between edges, then held across an enabled edge.
        applyStimulus(1'b1, 1'b0, 16'h00F0, 16'h0F00, 8'h10, 1'b1, 1'b0);
        @(posedge clk);
        #2;
        checkOutput("pre-reset out_q", 64'(out_q), 64'd1);
        checkOutput("pre-reset bus_out_q", 64'(bus_out_q), 64'h0FF0);
        checkOutput("pre-reset sticky", 64'(sticky), 64'd1);
        #1;
        reset = 1'b1;
        #1;
        checkOutput("async out_q", 64'(out_q), 64'd0);
        checkOutput("async bus_out_q", 64'(bus_out_q), 64'd0);
        checkOutput("async way_out_q", 64'(way_out_q), 64'd0);
        checkOutput("async sticky", 64'(sticky), 64'd0);
        checkOutput("async out", 64'(out), 64'd1);
        checkOutput("async bus_out", 64'(bus_out), 64'h0FF0);
        modelReset();
        @(posedge clk);
        #2;
        checkOutput("reset hold out_q", 64'(out_q), 64'd0);
        checkOutput("reset hold sticky", 64'(sticky), 64'd0);
        reset = 1'b0;

        // Sticky priority: clr beats a same-edge capture, then sets and holds.
        applyStimulus(1'b0, 1'b0, 16'h0000, 16'h0000, 8'h10, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b0, 16'h0000, 16'h0000, 8'h10, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 16'h0000, 16'h0000, 8'h00, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 16'h0000, 16'h0000, 8'h00, 1'b0, 1'b0);
        @(posedge clk);
        #2;
        checkOutput("sticky held", 64'(sticky), 64'd1);

        for (int i = 0; i < 300; i++) begin
            logic [7:0] wv;
            wv = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'(1 << $urandom_range(0, 7));
            applyStimulus(1'($urandom), 1'($urandom), W'($urandom), W'($urandom), wv,
                          $urandom_range(0, 9) < 7, $urandom_range(0, 9) == 0);
        end

        @(posedge clk);
        @(posedge clk);
        #2;
        checkOutput("scoreboard drained", 64'(sb.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
